// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin sharing of one fpu between NUM_REQ requesters, one operation in flight.
// Optional watchdog abort is compiled in with FPU_ARB_TIMEOUT_EN.
module fpu_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int WIDTH          = 32,
   parameter int OP_W           = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*OP_W-1:0]  req_operation,
   input  logic [NUM_REQ*WIDTH-1:0] req_data_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_data_b,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [NUM_REQ-1:0]       resp_valid,
   input  logic [NUM_REQ-1:0]       resp_ack,
   output logic [WIDTH-1:0]         resp_result,
   output logic                     resp_error,
   output logic                     busy,
   output logic                     fpu_reset,
   output logic [OP_W-1:0]          fpu_operation,
   output logic [WIDTH-1:0]         fpu_data_a,
   output logic [WIDTH-1:0]         fpu_data_b,
   output logic                     fpu_input_rdy,
   input  logic                     fpu_input_ack,
   input  logic                     fpu_output_rdy,
   output logic                     fpu_output_ack,
   input  logic [WIDTH-1:0]         fpu_result
);
   localparam int IW = $clog2(NUM_REQ);
   localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, WAIT = 3'd2, RELEASE = 3'd3, DELIVER = 3'd4;
   localparam logic [NUM_REQ-1:0] first_bit = 1;
   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("fpu_arbiter: parameter out of range");
   end
   logic [2:0]       state;
   logic [IW-1:0]    g, win, j;
   logic             fresh, timeout;
   logic [OP_W-1:0]  op;
   logic [WIDTH-1:0] a, b, res;
   // g doubles as the round-robin pointer: the last winner is searched last
   always_comb begin
      win = g;
      j = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         j = IW'((int'(g) + i) % NUM_REQ);
         if (req_valid[j]) win = j;
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         g     <= IW'(NUM_REQ - 1);
         fresh <= 1'b0;
         op    <= '0;
         a     <= '0;
         b     <= '0;
         res   <= '0;
      end else begin
         fresh <= 1'b0;
         if (timeout) begin
            state <= DELIVER;
            res   <= '1;
         end else begin
            case (state)
               IDLE: if (|req_valid) begin
                  g     <= win;
                  op    <= req_operation[win*OP_W +: OP_W];
                  a     <= req_data_a[win*WIDTH +: WIDTH];
                  b     <= req_data_b[win*WIDTH +: WIDTH];
                  fresh <= 1'b1;
                  state <= ISSUE;
               end
               ISSUE:   if (fpu_input_ack) state <= WAIT;
               WAIT: if (fpu_output_rdy) begin
                  res   <= fpu_result;
                  state <= RELEASE;
               end
               RELEASE: if (!fpu_output_rdy) state <= DELIVER;
               DELIVER: if (resp_ack[g]) state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end
`ifdef FPU_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt;
   logic          abort, err;
   assign timeout = (state == ISSUE || state == WAIT) && cnt == CW'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt   <= '0;
         abort <= 1'b0;
         err   <= 1'b0;
      end else begin
         abort <= timeout;
         cnt   <= (state == IDLE) ? '0 : (state == ISSUE || state == WAIT) ? cnt + 1'b1 : cnt;
         err   <= timeout | (err & !(state == DELIVER && resp_ack[g]));
      end
   end
   assign fpu_reset  = reset | abort;
   assign resp_error = err;
`else
   assign timeout    = 1'b0;
   assign fpu_reset  = reset;
   assign resp_error = 1'b0;
`endif
   assign busy           = state != IDLE;
   assign req_ready      = fresh ? first_bit << g : '0;
   assign resp_valid     = (state == DELIVER) ? first_bit << g : '0;
   assign resp_result    = res;
   assign fpu_input_rdy  = state == ISSUE;
   assign fpu_output_ack = state == RELEASE;
   assign fpu_operation  = op;
   assign fpu_data_a     = a;
   assign fpu_data_b     = b;
endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: vector table, directed corner cases and a randomized run against a
// round-robin reference model; a small behavioural fpu answers the handshakes.
module tb_fpu_arbiter;
   localparam int N = 4, W = 32, OW = 4, TO = 8;
   logic clock = 1'b0, reset;
   logic [N-1:0] req_valid, req_ready, resp_valid, resp_ack;
   logic [N*OW-1:0] req_operation;
   logic [N*W-1:0] req_data_a, req_data_b;
   logic [W-1:0] resp_result, fpu_data_a, fpu_data_b, fpu_result;
   logic [OW-1:0] fpu_operation;
   logic resp_error, busy, fpu_reset, fpu_input_rdy, fpu_input_ack, fpu_output_rdy, fpu_output_ack;
   always #5 clock = ~clock;

   fpu_arbiter #(.NUM_REQ(N), .WIDTH(W), .OP_W(OW), .TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_operation(req_operation),
      .req_data_a(req_data_a), .req_data_b(req_data_b), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_ack(resp_ack), .resp_result(resp_result),
      .resp_error(resp_error), .busy(busy), .fpu_reset(fpu_reset),
      .fpu_operation(fpu_operation), .fpu_data_a(fpu_data_a), .fpu_data_b(fpu_data_b),
      .fpu_input_rdy(fpu_input_rdy), .fpu_input_ack(fpu_input_ack),
      .fpu_output_rdy(fpu_output_rdy), .fpu_output_ack(fpu_output_ack), .fpu_result(fpu_result));

   int checks = 0, failures = 0;
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // fpu stand-in: the add vector from the datasheet example, otherwise an arbitrary mix
   function automatic logic [W-1:0] fmodel(input logic [OW-1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      if (o == 0 && x == 32'h3F800000 && y == 32'h3C23D70A) return 32'h3F8147AE;
      return (x + {y[15:0], y[31:16]}) ^ {28'h0, o};
   endfunction

   int ack_delay = 0, latency = 1, m_ph = 0, m_cnt = 0, m_lat = 1;
   bit never_out = 0, rand_lat = 0, err_seen = 0;
   logic [W-1:0] m_res;
   always @(posedge clock) begin
      if (fpu_reset) begin
         m_ph <= 0; m_cnt <= 0; fpu_input_ack <= 1'b0; fpu_output_rdy <= 1'b0; fpu_result <= '0;
      end else begin
         fpu_input_ack <= 1'b0;
         case (m_ph)
            0: if (fpu_input_rdy) begin
               if (m_cnt >= ack_delay) begin
                  fpu_input_ack <= 1'b1;
                  m_res <= fmodel(fpu_operation, fpu_data_a, fpu_data_b);
                  m_lat <= rand_lat ? int'($urandom_range(1, 4)) : latency;
                  m_ph <= 1; m_cnt <= 0;
               end else m_cnt <= m_cnt + 1;
            end
            1: if (!never_out) begin
               if (m_cnt + 1 >= m_lat) begin
                  fpu_output_rdy <= 1'b1; fpu_result <= m_res; m_ph <= 2; m_cnt <= 0;
               end else m_cnt <= m_cnt + 1;
            end
            2: if (fpu_output_ack) begin fpu_output_rdy <= 1'b0; m_ph <= 0; end
            default: m_ph <= 0;
         endcase
      end
   end
   always @(negedge clock) if (resp_error) err_seen <= 1'b1;

   logic [OW-1:0] op_of [N];
   logic [W-1:0] a_of [N], b_of [N];
   task automatic drive_ops();
      for (int i = 0; i < N; i++) begin
         req_operation[i*OW +: OW] = op_of[i];
         req_data_a[i*W +: W] = a_of[i];
         req_data_b[i*W +: W] = b_of[i];
      end
   endtask
   function automatic logic [N-1:0] onehot(input int k);
      logic [N-1:0] v = '0;
      if (k >= 0) v[k] = 1'b1;
      return v;
   endfunction
   // reference arbitration: first requester after the previous winner, wrapping around
   function automatic int pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction
   task automatic wait_ready(input int limit);
      int t = 0;
      while (req_ready == 0 && t < limit) begin resp_ack = resp_valid; @(negedge clock); t++; end
      resp_ack = '0;
   endtask
   task automatic txn(input logic [N-1:0] mask, output logic [N-1:0] rdy, output logic [N-1:0] rv, output logic [W-1:0] res);
      int t = 0;
      req_valid = mask;
      wait_ready(50);
      rdy = req_ready;
      req_valid = '0;
      while (resp_valid == 0 && t < 100) begin @(negedge clock); t++; end
      rv = resp_valid; res = resp_result;
      resp_ack = rv;
      @(negedge clock);
      resp_ack = '0;
   endtask
   task automatic drain();
      int t = 0;
      while (busy && t < 100) begin resp_ack = resp_valid; @(negedge clock); t++; end
      resp_ack = '0;
      check("drain_idle", busy, 0);
   endtask

   typedef struct { logic [N-1:0] mask; int exp; } vec_t;
   vec_t tbl [10];
   logic [N-1:0] rdy, rv;
   logic [W-1:0] res, held;
   int n, w, e, bad, spur, cycles, pulses, ow, delivered, rr;
   int rem [N];
   logic [W-1:0] exp_res;

   initial begin
      tbl[0] = '{4'b0001, 0}; tbl[1] = '{4'b1111, 1}; tbl[2] = '{4'b1001, 3}; tbl[3] = '{4'b1001, 0};
      tbl[4] = '{4'b0110, 1}; tbl[5] = '{4'b0100, 2}; tbl[6] = '{4'b0011, 0}; tbl[7] = '{4'b1100, 2};
      tbl[8] = '{4'b1010, 3}; tbl[9] = '{4'b0001, 0};
      for (int i = 0; i < N; i++) begin
         op_of[i] = OW'(i);
         a_of[i] = 32'h3F800000 + (32'(i) << 16);
         b_of[i] = 32'h3C23D70A + (32'(i) << 20);
      end
      reset = 1'b1; req_valid = '0; resp_ack = '0; drive_ops();
      repeat (2) @(negedge clock);
      check("reset_ctrl", {busy, req_ready, resp_valid, fpu_input_rdy, fpu_output_ack, resp_error}, 0);
      check("reset_fpu_reset", fpu_reset, 1);
      check("reset_result", resp_result, 0);
      reset = 1'b0;
      @(negedge clock);
      check("fpu_reset_release", fpu_reset, 0);

      txn(4'b0001, rdy, rv, res);
      check("t1_ready", rdy, 4'b0001);
      check("t1_resp", rv, 4'b0001);
      check("t1_result", res, 32'h3F8147AE);
      check("t1_idle", busy, 0);

      foreach (tbl[k]) begin
         txn(tbl[k].mask, rdy, rv, res);
         check("tbl_ready", rdy, onehot(tbl[k].exp));
         check("tbl_resp", rv, onehot(tbl[k].exp));
         check("tbl_result", res, fmodel(op_of[tbl[k].exp], a_of[tbl[k].exp], b_of[tbl[k].exp]));
         check("tbl_operand", fpu_data_a, a_of[tbl[k].exp]);
      end

      // reset while the fpu is computing
      latency = 20;
      req_valid = 4'b0010;
      wait_ready(50);
      req_valid = '0;
      n = 0;
      while (fpu_input_rdy && n < 50) begin @(negedge clock); n++; end
      @(negedge clock);
      check("t5_busy_before", busy, 1);
      reset = 1'b1; req_valid = 4'b1111;
      @(negedge clock);
      check("t5_state", {busy, resp_valid, req_ready}, 0);
      check("t5_fpu_reset", fpu_reset, 1);
      reset = 1'b0; latency = 3;

      // all requesters held: grants rotate starting from requester 0
      for (int k = 0; k < 5; k++) begin
         wait_ready(100);
         check("t2_grant", req_ready, onehot(k % N));
         @(negedge clock);
         check("t2_pulse", req_ready, 0);
      end
      req_valid = '0;
      drain();

      // fpu holds off input_ack: request and operands must stay put
      ack_delay = 5;
      req_valid = 4'b0100;
      wait_ready(50);
      req_valid = '0;
      pulses = 0; cycles = 0; bad = 0; n = 0;
      while (resp_valid == 0 && n < 100) begin
         if (req_ready != 0) pulses++;
         if (fpu_input_rdy) begin
            cycles++;
            if ({fpu_operation, fpu_data_a, fpu_data_b} != {op_of[2], a_of[2], b_of[2]}) bad++;
         end
         @(negedge clock); n++;
      end
      check("t3_ready_once", pulses, 1);
      check("t3_rdy_held", cycles >= 5, 1);
      check("t3_stable", bad, 0);
      check("t3_result", resp_result, fmodel(op_of[2], a_of[2], b_of[2]));
      drain();
      ack_delay = 0;

      // response withheld while another requester waits
      req_valid = 4'b0001;
      wait_ready(50);
      check("t4_grant0", req_ready, 4'b0001);
      req_valid = 4'b0010;
      n = 0;
      while (resp_valid == 0 && n < 100) begin @(negedge clock); n++; end
      held = resp_result; bad = 0; spur = 0;
      check("t4_result", held, fmodel(op_of[0], a_of[0], b_of[0]));
      resp_ack = 4'b1110;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         if (resp_valid != 4'b0001 || resp_result != held) bad++;
         if (req_ready != 0) spur++;
      end
      check("t4_held", bad, 0);
      check("t4_no_grant", spur, 0);
      resp_ack = 4'b0001;
      @(negedge clock);
      resp_ack = '0;
      wait_ready(50);
      check("t4_grant1", req_ready, 4'b0010);
      req_valid = '0;
      drain();

`ifdef FPU_ARB_TIMEOUT_EN
      never_out = 1;
      req_valid = 4'b1000;
      wait_ready(50);
      req_valid = '0;
      w = pick(req_ready, -1);
      n = 0;
      while (!fpu_reset && n < 50) begin @(negedge clock); n++; end
      check("t6_delay", n, TO);
      check("t6_resp", resp_valid, onehot(w));
      check("t6_error", resp_error, 1);
      check("t6_result", resp_result, 32'hFFFFFFFF);
      never_out = 0;
      resp_ack = resp_valid;
      @(negedge clock);
      resp_ack = '0;
      check("t6_after", {fpu_reset, resp_error, busy}, 0);
`else
      check("no_error_ever", err_seen, 0);
`endif

      // randomized traffic against the reference model
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0; rr = N - 1; ow = -1; delivered = 0; rand_lat = 1;
      for (int i = 0; i < N; i++) begin
         rem[i] = 6;
         op_of[i] = OW'($urandom); a_of[i] = $urandom; b_of[i] = $urandom;
      end
      req_valid = '0; drive_ops();
      for (int cyc = 0; cyc < 4000 && delivered < N * 6; cyc++) begin
         @(negedge clock);
         if (req_ready != 0) begin
            e = pick(req_valid, rr);
            check("rand_grant", req_ready, onehot(e));
            check("rand_one_in_flight", ow < 0, 1);
            if (e >= 0) begin
               check("rand_operand", {fpu_operation, fpu_data_b}, {op_of[e], b_of[e]});
               rr = e; ow = e;
               exp_res = fmodel(op_of[e], a_of[e], b_of[e]);
               rem[e]--;
               op_of[e] = OW'($urandom); a_of[e] = $urandom; b_of[e] = $urandom;
               req_valid[e] = rem[e] > 0 && $urandom_range(0, 1) == 1;
            end
         end
         if (resp_valid != 0) begin
            check("rand_resp", resp_valid, onehot(ow));
            check("rand_result", resp_result, exp_res);
            if ($urandom_range(0, 2) == 0) begin
               resp_ack = resp_valid | N'($urandom);
               delivered++; ow = -1;
            end else resp_ack = N'($urandom) & ~resp_valid;
         end else resp_ack = N'($urandom);
         for (int i = 0; i < N; i++)
            if (!req_valid[i] && rem[i] > 0 && $urandom_range(0, 3) == 0) req_valid[i] = 1'b1;
         drive_ops();
      end
      check("rand_delivered", delivered, N * 6);
      resp_ack = '0; req_valid = '0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
endmodule
